// File: rtl/rom_sync.sv
// Synchronous program memory with a zero-fill clear sequencer after reset, a
// LATENCY-deep registered read pipeline with range checking, and a run-time load port.
module rom_sync #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic [ADDR_W-1:0] adrs,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_adrs,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  output logic              busy,
  output logic              o_dbg_state
);

  // Handshake: a read is accepted on any edge where rd=1 and busy=0; its result
  // appears as a single-cycle dvalid LATENCY cycles later. There is no back-pressure.
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_err;
  logic [DATA_W-1:0]  r_dat [LATENCY];
  logic               r_ld_err;

  logic               w_busy;
  logic               w_rd_acc;
  logic               w_rd_oor;
  logic               w_ld_oor;
  logic               w_ld_acc;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [IDX_W-1:0]   w_ld_idx;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_CLEAR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: if (r_cnt == LAST_IDX) w_next = S_RUN;
      S_RUN:   w_next = S_RUN;
      default: w_next = S_CLEAR;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (r_state == S_CLEAR && r_cnt != LAST_IDX)
      r_cnt <= r_cnt + IDX_W'(1);
  end

  // Unsigned compare at full address width; never true when DEPTH == 2**ADDR_W.
  assign w_rd_oor = ({1'b0, adrs} >= DEPTH_X);
  assign w_ld_oor = ({1'b0, ld_adrs} >= DEPTH_X);
  assign w_rd_idx = adrs[IDX_W-1:0];
  assign w_ld_idx = ld_adrs[IDX_W-1:0];
  assign w_rd_acc = rd & ~w_busy;
  assign w_ld_acc = ld_en & ~w_busy & ~w_ld_oor;

  // Array has no reset; the clear sequencer is what zero-fills it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR)
        r_mem[r_cnt] <= '0;
      else if (w_ld_acc)
        r_mem[w_ld_idx] <= ld_data;
    end
  end

  // Read pipeline: data stages only load behind a valid bit, so dout holds between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < LATENCY; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= w_rd_acc;
      r_err[0] <= w_rd_acc & w_rd_oor;
      if (w_rd_acc) r_dat[0] <= w_rd_oor ? '0 : r_mem[w_rd_idx];
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_ld_err <= 1'b0;
    else       r_ld_err <= ld_en & (w_busy | w_ld_oor);
  end

  assign dout        = r_dat[LATENCY-1];
  assign dvalid      = r_vld[LATENCY-1];
  assign err         = r_err[LATENCY-1];
  assign ld_err      = r_ld_err;
  assign busy        = w_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rom_sync.sv
// Bench for rom_sync: three instances (LATENCY 1..3) share one stimulus stream and are
// checked against an array/queue reference model of the memory and its read timing.
module tb_rom_sync;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          rd = 1'b0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] adrs = '0;
  logic [AW-1:0] ld_adrs = '0;
  logic [DW-1:0] ld_data = '0;

  logic [DW-1:0] dout_a [3];
  logic [2:0]    dv_a, err_a, lderr_a, busy_a, st_a;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rom_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(g + 1)) u_dut (
      .clk(clk), .reset(reset), .rd(rd), .adrs(adrs),
      .dout(dout_a[g]), .dvalid(dv_a[g]), .err(err_a[g]),
      .ld_en(ld_en), .ld_adrs(ld_adrs), .ld_data(ld_data),
      .ld_err(lderr_a[g]), .busy(busy_a[g]), .o_dbg_state(st_a[g])
    );
  end

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [40:0]   exp_q [3][$];
  logic [DW-1:0] last_dout [3];
  int            busy_left;
  int            edge_no;
  logic [2:0]    e_dv, e_err;
  logic [DW-1:0] e_dout [3];
  logic          e_ld_err, e_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] prog [7];

  task automatic idle_inputs();
    rd = 1'b0; ld_en = 1'b0;
  endtask

  // Advance one clock, updating the model for that edge and computing expected outputs.
  task automatic step();
    logic          oor;
    logic [DW-1:0] d;
    logic [40:0]   item;
    if (reset) begin
      busy_left = DEPTH;
      for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
      for (int i = 0; i < 3; i++) begin exp_q[i].delete(); last_dout[i] = '0; end
      e_ld_err = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      e_ld_err = ld_en;
    end else begin
      if (rd) begin
        oor = (adrs >= DEPTH);
        d   = oor ? '0 : m_mem[adrs[4:0]];
        for (int i = 0; i < 3; i++) exp_q[i].push_back({32'(edge_no + i), oor, d});
      end
      if (ld_en && ld_adrs < DEPTH) m_mem[ld_adrs[4:0]] = ld_data;
      e_ld_err = ld_en && (ld_adrs >= DEPTH);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e_dv[i] = 1'b0; e_err[i] = 1'b0; e_dout[i] = last_dout[i];
      if (exp_q[i].size() > 0) begin
        item = exp_q[i][0];
        if (item[40:9] == 32'(edge_no)) begin
          void'(exp_q[i].pop_front());
          e_dv[i] = 1'b1; e_err[i] = item[8]; e_dout[i] = item[7:0];
          last_dout[i] = item[7:0];
        end
      end
    end
    e_busy = (busy_left > 0);
    edge_no++;
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1; idle_inputs();
    step(); step();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (dv_a[i] !== 1'b0 || err_a[i] !== 1'b0 || dout_a[i] !== 8'h00 ||
          lderr_a[i] !== 1'b0 || busy_a[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_values L%0d: dv=%b err=%b dout=%h lderr=%b busy=%b, expected 0 0 00 0 1",
                 i + 1, dv_a[i], err_a[i], dout_a[i], lderr_a[i], busy_a[i]);
      end
    end
    reset = 1'b0;
    cnt = 0;
    while (busy_a !== 3'b000 && cnt < 100) begin
      step(); cnt++;
      n_tests++;
      if (busy_a !== {3{e_busy}}) begin
        n_fail++;
        $display("FAIL clear_busy edge %0d: busy=%b expected %b", edge_no, busy_a, {3{e_busy}});
      end
    end
    n_tests++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL clear_length: busy for %0d cycles, expected %0d", cnt, DEPTH);
    end
    for (int k = 0; k < DEPTH + 3; k++) begin
      rd = (k < DEPTH); adrs = AW'(k);
      step();
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (dv_a[i] !== e_dv[i] || err_a[i] !== e_err[i] || dout_a[i] !== e_dout[i] ||
            (e_dv[i] && dout_a[i] !== 8'h00)) begin
          n_fail++;
          $display("FAIL read_zero L%0d edge %0d: dv=%b err=%b dout=%h, expected %b %b %h",
                   i + 1, edge_no, dv_a[i], err_a[i], dout_a[i], e_dv[i], e_err[i], e_dout[i]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_load_readback();
    for (int k = 0; k < 7; k++) begin
      ld_en = 1'b1; ld_adrs = AW'(k); ld_data = prog[k];
      step();
      n_tests++;
      if (lderr_a !== 3'b000) begin
        n_fail++;
        $display("FAIL load_ok adr %0d: ld_err=%b expected 000", k, lderr_a);
      end
    end
    ld_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rd = (k < 7); adrs = AW'(k);
      step();
      if (k < 7) begin
        n_tests++;
        if (dv_a[0] !== 1'b1 || err_a[0] !== 1'b0 || dout_a[0] !== prog[k]) begin
          n_fail++;
          $display("FAIL readback L1 adr %0d: dv=%b err=%b dout=%h, expected 1 0 %h",
                   k, dv_a[0], err_a[0], dout_a[0], prog[k]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (dv_a[i] !== e_dv[i] || err_a[i] !== e_err[i] || dout_a[i] !== e_dout[i]) begin
          n_fail++;
          $display("FAIL readback_model L%0d edge %0d: dv=%b err=%b dout=%h, expected %b %b %h",
                   i + 1, edge_no, dv_a[i], err_a[i], dout_a[i], e_dv[i], e_err[i], e_dout[i]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_latency3();
    logic [2:0]    exp_dv [5];
    logic [DW-1:0] exp_d  [5];
    exp_dv = '{3'b0, 3'b0, 3'b1, 3'b1, 3'b0};
    exp_d  = '{8'h00, 8'h00, 8'h24, 8'h04, 8'h04};
    for (int k = 0; k < 5; k++) begin
      rd = (k < 2); adrs = AW'(k + 1);
      step();
      n_tests++;
      if (dv_a[2] !== exp_dv[k][0] || (exp_dv[k][0] && dout_a[2] !== exp_d[k]) ||
          err_a[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL latency3 step %0d: dv=%b dout=%h err=%b, expected %b %h 0",
                 k, dv_a[2], dout_a[2], err_a[2], exp_dv[k][0], exp_d[k]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    rd = 1'b1; adrs = 8'h20;
    step();
    rd = 1'b0;
    n_tests++;
    if (dv_a[0] !== 1'b1 || err_a[0] !== 1'b1 || dout_a[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_read: dv=%b err=%b dout=%h, expected 1 1 00", dv_a[0], err_a[0], dout_a[0]);
    end
    step(); step();
    n_tests++;
    if (dv_a[2] !== 1'b1 || err_a[2] !== 1'b1 || dout_a[2] !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_read_L3: dv=%b err=%b dout=%h, expected 1 1 00", dv_a[2], err_a[2], dout_a[2]);
    end
    ld_en = 1'b1; ld_adrs = 8'h40; ld_data = 8'hFF;
    step();
    ld_en = 1'b0;
    n_tests++;
    if (lderr_a !== 3'b111) begin
      n_fail++;
      $display("FAIL oor_load_pulse: ld_err=%b expected 111", lderr_a);
    end
    step();
    n_tests++;
    if (lderr_a !== 3'b000) begin
      n_fail++;
      $display("FAIL oor_load_end: ld_err=%b expected 000", lderr_a);
    end
    for (int k = 0; k < DEPTH + 3; k++) begin
      rd = (k < DEPTH); adrs = AW'(k);
      step();
      if (k < DEPTH) begin
        n_tests++;
        if (dout_a[0] !== ((k < 7) ? prog[k] : 8'h00) || err_a[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL oor_unchanged adr %0d: dout=%h err=%b, expected %h 0",
                   k, dout_a[0], err_a[0], (k < 7) ? prog[k] : 8'h00);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_read_before_write();
    rd = 1'b1; adrs = 8'd5; ld_en = 1'b1; ld_adrs = 8'd5; ld_data = 8'h99;
    step();
    ld_en = 1'b0;
    n_tests++;
    if (dv_a[0] !== 1'b1 || dout_a[0] !== 8'h27) begin
      n_fail++;
      $display("FAIL rbw_old: dv=%b dout=%h, expected 1 27", dv_a[0], dout_a[0]);
    end
    step();
    rd = 1'b0;
    n_tests++;
    if (dv_a[0] !== 1'b1 || dout_a[0] !== 8'h99) begin
      n_fail++;
      $display("FAIL rbw_new: dv=%b dout=%h, expected 1 99", dv_a[0], dout_a[0]);
    end
    step(); step();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rd      = ($urandom_range(0, 9) < 6);
      adrs    = AW'($urandom_range(0, 40));
      ld_en   = ($urandom_range(0, 9) < 3);
      ld_adrs = AW'($urandom_range(0, 40));
      ld_data = DW'($urandom);
      step();
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (dv_a[i] !== e_dv[i] || err_a[i] !== e_err[i] || dout_a[i] !== e_dout[i] ||
            lderr_a[i] !== e_ld_err || busy_a[i] !== e_busy) begin
          n_fail++;
          $display("FAIL random L%0d edge %0d: dv=%b err=%b dout=%h lderr=%b busy=%b, expected %b %b %h %b %b",
                   i + 1, edge_no, dv_a[i], err_a[i], dout_a[i], lderr_a[i], busy_a[i],
                   e_dv[i], e_err[i], e_dout[i], e_ld_err, e_busy);
        end
      end
    end
    idle_inputs();
    step(); step(); step();
  endtask

  task automatic test_reset_midop();
    int cnt;
    ld_en = 1'b1; ld_adrs = 8'd1; ld_data = 8'h5A;
    step();
    ld_en = 1'b0; rd = 1'b1; adrs = 8'd1;
    step();
    rd = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if (dv_a[1] !== 1'b0 || dv_a[2] !== 1'b0 || busy_a !== 3'b111) begin
      n_fail++;
      $display("FAIL midop_flush: dv=%b busy=%b, expected dv[2:1]=00 busy=111", dv_a, busy_a);
    end
    cnt = 0;
    while (busy_a !== 3'b000 && cnt < 100) begin
      ld_en = (cnt == 3); ld_adrs = 8'd2; ld_data = 8'hAA;
      rd    = (cnt == 5); adrs = 8'd2;
      step(); cnt++;
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (dv_a[i] !== e_dv[i] || err_a[i] !== e_err[i] || dout_a[i] !== e_dout[i] ||
            lderr_a[i] !== e_ld_err || busy_a[i] !== e_busy) begin
          n_fail++;
          $display("FAIL midop_clear L%0d edge %0d: dv=%b err=%b dout=%h lderr=%b busy=%b, expected %b %b %h %b %b",
                   i + 1, edge_no, dv_a[i], err_a[i], dout_a[i], lderr_a[i], busy_a[i],
                   e_dv[i], e_err[i], e_dout[i], e_ld_err, e_busy);
        end
      end
    end
    idle_inputs();
    n_tests++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL midop_clear_length: busy for %0d cycles, expected %0d", cnt, DEPTH);
    end
    for (int k = 0; k < DEPTH + 3; k++) begin
      rd = (k < DEPTH); adrs = AW'(k);
      step();
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (dv_a[i] !== e_dv[i] || err_a[i] !== e_err[i] || dout_a[i] !== e_dout[i] ||
            (e_dv[i] && dout_a[i] !== 8'h00)) begin
          n_fail++;
          $display("FAIL midop_zero L%0d edge %0d: dv=%b dout=%h, expected %b %h",
                   i + 1, edge_no, dv_a[i], dout_a[i], e_dv[i], e_dout[i]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    prog = '{8'h02, 8'h24, 8'h04, 8'h25, 8'h05, 8'h27, 8'h06};
    edge_no = 0;
    busy_left = DEPTH;
    test_reset();
    test_load_readback();
    test_latency3();
    test_out_of_range();
    test_read_before_write();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
